// File: rtl/sc_scbc_rarb.sv
// Two-master round-robin register arbiter: one slave access at a time; sync ACK two cycles after REQ,
// async ACK one cycle after S_COMP or after TIMEOUT WAIT cycles with ERR; requesters hold REQ until ACK.
module sc_scbc_rarb #(
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  SYSCLK,
   input  logic                  SYSRSTB,
   input  logic                  M0_REQ,
   input  logic                  M0_WR,
   input  logic [ADDR_WIDTH-1:0] M0_ADR,
   input  logic [31:0]           M0_WDAT,
   input  logic [3:0]            M0_WSTB,
   output logic                  M0_ACK,
   output logic [31:0]           M0_RDAT,
   output logic                  M0_ERR,
   input  logic                  M1_REQ,
   input  logic                  M1_WR,
   input  logic [ADDR_WIDTH-1:0] M1_ADR,
   input  logic [31:0]           M1_WDAT,
   input  logic [3:0]            M1_WSTB,
   output logic                  M1_ACK,
   output logic [31:0]           M1_RDAT,
   output logic                  M1_ERR,
   output logic                  S_WENB,
   output logic                  S_RENB,
   output logic [ADDR_WIDTH-1:0] S_ADR,
   output logic [31:0]           S_WDAT,
   output logic [3:0]            S_WSTB,
   input  logic                  S_ASYNC,
   input  logic                  S_COMP,
   input  logic [31:0]           S_RDAT,
   output logic                  BUSY
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t                state_q, state_d;
   logic                  gnt_q, gnt_d;
   logic                  last_q, last_d;
   logic                  wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [31:0]           wdat_q, wdat_d;
   logic [3:0]            wstb_q, wstb_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  wenb_q, wenb_d;
   logic                  renb_q, renb_d;
   logic                  busy_q, busy_d;
   logic                  ack0_q, ack0_d, ack1_q, ack1_d;
   logic                  err0_q, err0_d, err1_q, err1_d;
   logic [31:0]           rdat0_q, rdat0_d, rdat1_q, rdat1_d;
   logic                  fin, fin_err, fin_ld;
   logic [31:0]           fin_dat;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      wr_d    = wr_q;
      adr_d   = adr_q;
      wdat_d  = wdat_q;
      wstb_d  = wstb_q;
      cnt_d   = cnt_q;
      wenb_d  = 1'b0;
      renb_d  = 1'b0;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      err0_d  = err0_q;
      err1_d  = err1_q;
      rdat0_d = rdat0_q;
      rdat1_d = rdat1_q;
      fin     = 1'b0;
      fin_err = 1'b0;
      fin_ld  = 1'b0;
      fin_dat = S_RDAT;
      case (state_q)
         IDLE: begin
            if (M0_REQ || M1_REQ) begin
               // On contention the master that did not win last time goes first.
               gnt_d   = (M0_REQ && M1_REQ) ? ~last_q : M1_REQ;
               wr_d    = gnt_d ? M1_WR   : M0_WR;
               adr_d   = gnt_d ? M1_ADR  : M0_ADR;
               wdat_d  = gnt_d ? M1_WDAT : M0_WDAT;
               wstb_d  = gnt_d ? M1_WSTB : M0_WSTB;
               wenb_d  = wr_d;
               renb_d  = ~wr_d;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (S_ASYNC) begin
               cnt_d   = '0;
               state_d = WAIT;
            end else begin
               fin    = 1'b1;
               fin_ld = ~wr_q;
            end
         end
         WAIT: begin
            // Completion is tested before the timeout so a coincident S_COMP wins.
            if (S_COMP) begin
               fin    = 1'b1;
               fin_ld = ~wr_q;
            end else if (cnt_q == TO_LAST) begin
               fin     = 1'b1;
               fin_err = 1'b1;
               fin_ld  = 1'b1;
               fin_dat = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE: begin
            last_d  = gnt_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (fin) begin
         state_d = DONE;
         if (gnt_q) begin
            ack1_d = 1'b1;
            err1_d = fin_err;
            if (fin_ld) rdat1_d = fin_dat;
         end else begin
            ack0_d = 1'b1;
            err0_d = fin_err;
            if (fin_ld) rdat0_d = fin_dat;
         end
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
      if (!SYSRSTB) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         wr_q    <= 1'b0;
         adr_q   <= '0;
         wdat_q  <= '0;
         wstb_q  <= '0;
         cnt_q   <= '0;
         wenb_q  <= 1'b0;
         renb_q  <= 1'b0;
         busy_q  <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         err0_q  <= 1'b0;
         err1_q  <= 1'b0;
         rdat0_q <= '0;
         rdat1_q <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         wr_q    <= wr_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         wstb_q  <= wstb_d;
         cnt_q   <= cnt_d;
         wenb_q  <= wenb_d;
         renb_q  <= renb_d;
         busy_q  <= busy_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         err0_q  <= err0_d;
         err1_q  <= err1_d;
         rdat0_q <= rdat0_d;
         rdat1_q <= rdat1_d;
      end
   end

   assign M0_ACK  = ack0_q;
   assign M0_ERR  = err0_q;
   assign M0_RDAT = rdat0_q;
   assign M1_ACK  = ack1_q;
   assign M1_ERR  = err1_q;
   assign M1_RDAT = rdat1_q;
   assign S_WENB  = wenb_q;
   assign S_RENB  = renb_q;
   assign S_ADR   = adr_q;
   assign S_WDAT  = wdat_q;
   assign S_WSTB  = wstb_q;
   assign BUSY    = busy_q;

endmodule

// File: doc/sc_scbc_rarb.md
SC_SCBC_RARB -- requirements
Module: sc_scbc_rarb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning register address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, range 1..255, meaning maximum WAIT cycles allowed for an async slave completion.
REQ-003 SHALL have port SYSCLK, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port SYSRSTB, input, 1, reset: asynchronous assertion, active-low.
REQ-005 SHALL have ports M0_REQ / M1_REQ, input, 1, access request; held high until that requester's ACK.
REQ-006 SHALL have ports M0_WR / M1_WR, input, 1, access type: 1 = write, 0 = read.
REQ-007 SHALL have ports M0_ADR / M1_ADR, input, ADDR_WIDTH, access address.
REQ-008 SHALL have ports M0_WDAT / M1_WDAT, input, 32, write data.
REQ-009 SHALL have ports M0_WSTB / M1_WSTB, input, 4, write byte enables.
REQ-010 SHALL have ports M0_ACK / M1_ACK, output, 1, one-cycle access-complete pulse.
REQ-011 SHALL have ports M0_RDAT / M1_RDAT, output, 32, read data; valid while the matching ACK is high.
REQ-012 SHALL have ports M0_ERR / M1_ERR, output, 1, timeout error; valid while the matching ACK is high.
REQ-013 SHALL have port S_WENB, output, 1, slave write-enable pulse.
REQ-014 SHALL have port S_RENB, output, 1, slave read-enable pulse.
REQ-015 SHALL have ports S_ADR (output, ADDR_WIDTH), S_WDAT (output, 32) and S_WSTB (output, 4), latched access fields.
REQ-016 SHALL have port S_ASYNC, input, 1, combinational decode of S_ADR: 1 = target is in the ULPI (async) domain.
REQ-017 SHALL have port S_COMP, input, 1, async completion pulse from the synchronizer.
REQ-018 SHALL have port S_RDAT, input, 32, slave read data.
REQ-019 SHALL have port BUSY, output, 1, high whenever the state is not IDLE.

Function
REQ-020 FSM SHALL have states IDLE, ISSUE, WAIT and DONE; each state lasts one cycle except WAIT.
REQ-021 IDLE: if any REQ is high, the block SHALL grant exactly one requester, latch that requester's WR/ADR/WDAT/WSTB into the S_ registers and the grant index, then go to ISSUE; REQ is sampled only in IDLE.
REQ-022 Arbitration SHALL be round-robin on a last-grant pointer (reset 1, so M0 wins the first contention); with a single requester active, that requester wins.
REQ-023 ISSUE: the block SHALL drive S_WENB (write) or S_RENB (read) high for exactly this cycle, never both.
REQ-024 ISSUE with S_ASYNC=0: the block SHALL capture S_RDAT (reads) and go to DONE.
REQ-025 ISSUE with S_ASYNC=1: the block SHALL clear the 8-bit timeout counter and go to WAIT.
REQ-026 WAIT with S_COMP=1: the block SHALL capture S_RDAT, clear the error flag and go to DONE.
REQ-027 WAIT with S_COMP=0: the counter SHALL increment each cycle; on the TIMEOUT-th WAIT cycle without S_COMP, the block SHALL set the error flag, load read data 32'h0 and go to DONE.
REQ-028 If S_COMP arrives in the same cycle the timeout would fire, completion SHALL win and no error is flagged.
REQ-029 S_COMP outside WAIT (stray, or late after a timeout) SHALL be ignored.
REQ-030 DONE: the block SHALL pulse the granted Mn_ACK for one cycle with Mn_RDAT/Mn_ERR valid, update the last-grant pointer and go to IDLE.
REQ-031 The non-granted ACK SHALL stay 0; Mn_RDAT/Mn_ERR SHALL hold their last values outside ACK.
REQ-032 Latency: sync access SHALL give REQ sampled in cycle 0, enable in cycle 1, ACK in cycle 2; async access SHALL give ACK one cycle after the S_COMP cycle.
REQ-033 Requesters SHALL drop REQ in the cycle after ACK, or keep REQ high to start a new access; back-to-back contention SHALL alternate grants.
REQ-034 S_ADR/S_WDAT/S_WSTB SHALL stay stable from ISSUE through DONE.

Reset
REQ-035 SYSRSTB low SHALL immediately force state IDLE; all ACK/ERR/S_WENB/S_RENB/BUSY = 0; S_ADR/S_WDAT/S_RDAT latches = 0; S_WSTB = 0; counter = 0; last-grant pointer = 1.
REQ-036 Reset mid-access (ISSUE/WAIT/DONE) SHALL abort it with no ACK issued; a pending S_COMP after reset is ignored per REQ-029.

Verification
REQ-037 M0 sync read ADR=0x10, S_ASYNC=0, S_RDAT=0x12345678 -> S_RENB in cycle 1, M0_ACK in cycle 2, M0_RDAT=0x12345678, M0_ERR=0.
REQ-038 M0 and M1 write simultaneously from reset, both holding REQ -> grant order M0, M1, M0; M1 WDAT 0xA5A5A5A5 / WSTB 0xF appear on S_WDAT/S_WSTB during its ISSUE.
REQ-039 M1 async write, S_COMP after 5 WAIT cycles -> M1_ACK one cycle later, M1_ERR=0.
REQ-040 TIMEOUT=4, async read, no S_COMP -> ACK after 4 WAIT cycles, ERR=1, RDAT=0x0; S_COMP 2 cycles later -> ignored, BUSY stays 0.
REQ-041 S_COMP on the TIMEOUT-th WAIT cycle -> ERR=0, data captured.
REQ-042 SYSRSTB low during WAIT -> outputs at reset values immediately, no ACK; after release, a new M0 request completes normally.
